// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the tinyriscv trap path.
//   trap_state_e : trap sequencer states
//   Csr*         : machine-mode CSR addresses
//   Inst*        : SYSTEM instruction encodings recognised in decode
//   Cause*       : mcause values written on trap entry
//   mstatus_trap_entry / mstatus_trap_return : MIE/MPIE bit-field updates
package tinyriscv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    W_MRET    = 3'd4,
    ASSERT    = 3'd5
  } trap_state_e;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtvec   = 12'h305;

  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  localparam logic [31:0] CauseEcall   = 32'd11;
  localparam logic [31:0] CauseEbreak  = 32'd3;
  localparam logic [31:0] CauseIrqBase = 32'h8000_0000;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] mstatus_trap_entry(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE is restored from MPIE, MPIE is set.
  function automatic logic [31:0] mstatus_trap_return(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder over the external interrupt lines.
//   req_i   : interrupt request vector
//   valid_o : at least one request is set
//   idx_o   : index of the lowest set request (0 when none)
module irq_prio_enc #(
  parameter int Width = 8
) (
  input  logic [Width-1:0]         req_i,
  output logic                     valid_o,
  output logic [$clog2(Width)-1:0] idx_o
);

  localparam int IdxW = $clog2(Width);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      valid_o = valid_o | req_i[i];
      idx_o   = req_i[i] ? IdxW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: detects ecall/ebreak/mret in decode (and, when
// TRAP_CTRL_ASYNC_IRQ_EN is defined, external interrupts), holds the
// pipeline, writes mepc/mcause/mstatus over a dedicated CSR port and
// issues a one-cycle redirect.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   inst_i, inst_addr_i     : decode instruction and its address
//   jump_flag_i/jump_addr_i : execute-stage jump (flushes decode)
//   ex_busy_i, int_flag_i   : interrupt deferral / request lines
//   csr_*_i                 : current mtvec, mepc, mstatus
//   hold_flag_o             : hold request (combinational in detect cycle)
//   csr_we_o/waddr_o/wdata_o: registered CSR write port
//   int_assert_o/int_addr_o : registered one-cycle redirect
// Macro TRAP_CTRL_ASYNC_IRQ_EN: compiles in the external interrupt path.
module trap_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int InstAddrBus = 32,
  parameter int IntBus      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            inst_i,
  input  logic [InstAddrBus-1:0] inst_addr_i,
  input  logic                   jump_flag_i,
  input  logic [InstAddrBus-1:0] jump_addr_i,
  input  logic                   ex_busy_i,
  input  logic [IntBus-1:0]      int_flag_i,
  input  logic [31:0]            csr_mtvec_i,
  input  logic [31:0]            csr_mepc_i,
  input  logic [31:0]            csr_mstatus_i,
  output logic                   hold_flag_o,
  output logic                   csr_we_o,
  output logic [11:0]            csr_waddr_o,
  output logic [31:0]            csr_wdata_o,
  output logic                   int_assert_o,
  output logic [InstAddrBus-1:0] int_addr_o
);

  trap_state_e state_r;
  logic [31:0] cause_r;

  logic        sync_trap_s;
  logic        mret_trap_s;
  logic        irq_trap_s;
  logic        trap_det_s;
  logic [31:0] det_epc_s;
  logic [31:0] det_cause_s;

`ifdef TRAP_CTRL_ASYNC_IRQ_EN
  logic                      irq_valid_s;
  logic [$clog2(IntBus)-1:0] irq_idx_s;

  irq_prio_enc #(
    .Width (IntBus)
  ) u_irq_prio_enc (
    .req_i   (int_flag_i),
    .valid_o (irq_valid_s),
    .idx_o   (irq_idx_s)
  );
`else
  logic unused_irq_s;
  assign unused_irq_s = ^{int_flag_i, ex_busy_i, jump_addr_i};
`endif

  // Trap detection in decode; a taken jump flushes the decode slot so
  // SYSTEM instructions there are not real, but interrupts still apply.
  always_comb begin
    sync_trap_s = !rst_i && !jump_flag_i &&
                  ((inst_i == InstEcall) || (inst_i == InstEbreak));
    mret_trap_s = !rst_i && !jump_flag_i && !sync_trap_s && (inst_i == InstMret);
    det_epc_s   = 32'(inst_addr_i);
    det_cause_s = (inst_i == InstEbreak) ? CauseEbreak : CauseEcall;
`ifdef TRAP_CTRL_ASYNC_IRQ_EN
    irq_trap_s  = !rst_i && irq_valid_s && csr_mstatus_i[3] && !ex_busy_i &&
                  !sync_trap_s && !mret_trap_s;
    det_epc_s   = (irq_trap_s && jump_flag_i) ? 32'(jump_addr_i) : det_epc_s;
    det_cause_s = irq_trap_s ? (CauseIrqBase | 32'(irq_idx_s)) : det_cause_s;
`else
    irq_trap_s  = 1'b0;
`endif
    trap_det_s  = (state_r == IDLE) && (sync_trap_s || mret_trap_s || irq_trap_s);
  end

  // Hold must cover the detection cycle itself, hence not registered.
  assign hold_flag_o = (state_r != IDLE) || trap_det_s;

  // Sequencer: each state loads the write/redirect shown in the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cause_r      <= 32'h0000_0000;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= 12'h000;
      csr_wdata_o  <= 32'h0000_0000;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= 12'h000;
      csr_wdata_o  <= 32'h0000_0000;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state_r)
        IDLE: begin
          if (trap_det_s && mret_trap_s) begin
            state_r     <= W_MRET;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CsrMstatus;
            csr_wdata_o <= mstatus_trap_return(csr_mstatus_i);
          end else if (trap_det_s) begin
            state_r     <= W_MEPC;
            cause_r     <= det_cause_s;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CsrMepc;
            csr_wdata_o <= det_epc_s;
          end else begin
            state_r     <= IDLE;
          end
        end
        W_MEPC: begin
          state_r     <= W_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CsrMcause;
          csr_wdata_o <= cause_r;
        end
        W_MCAUSE: begin
          state_r     <= W_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CsrMstatus;
          csr_wdata_o <= mstatus_trap_entry(csr_mstatus_i);
        end
        W_MSTATUS: begin
          state_r      <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= InstAddrBus'(csr_mtvec_i);
        end
        W_MRET: begin
          state_r      <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= InstAddrBus'(csr_mepc_i);
        end
        ASSERT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised and directed bench for trap_ctrl with an in-bench reference
// model: a queue of expected per-cycle outputs scheduled when a trap is seen.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ex_busy_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        hold_flag_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .ex_busy_i     (ex_busy_i),
    .int_flag_i    (int_flag_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .hold_flag_o   (hold_flag_o),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        asrt;
    logic [31:0] addr;
  } out_t;

  out_t exp_q[$];
  out_t got;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic out_t mk(input logic h, input logic we, input logic [11:0] wa,
                              input logic [31:0] wd, input logic a, input logic [31:0] ad);
    out_t o;
    o.hold = h; o.we = we; o.waddr = wa; o.wdata = wd; o.asrt = a; o.addr = ad;
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Schedule the full trap-entry sequence: 5 held cycles, 3 writes, redirect.
  task automatic push_entry(input logic [31:0] epc, input logic [31:0] cause);
    logic [31:0] ms;
    ms = (csr_mstatus_i & ~32'h0000_0088) | (csr_mstatus_i[3] ? 32'h0000_0080 : 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h341, epc, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ms, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, csr_mtvec_i));
  endtask

  // Model: when idle, look at this cycle's inputs and schedule outputs.
  task automatic model_cycle(output out_t e);
    logic [31:0] ms;
    logic [31:0] cause;
    if (exp_q.size() == 0) begin
      if (!rst_i && !jump_flag_i && (inst_i == ECALL || inst_i == EBREAK)) begin
        push_entry(inst_addr_i, (inst_i == ECALL) ? 32'd11 : 32'd3);
      end else if (!rst_i && !jump_flag_i && inst_i == MRET) begin
        ms = (csr_mstatus_i & ~32'h0000_0008) | 32'h0000_0080 |
             (csr_mstatus_i[7] ? 32'h0000_0008 : 32'h0);
        exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ms, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, csr_mepc_i));
`ifdef TRAP_CTRL_ASYNC_IRQ_EN
      end else if (!rst_i && int_flag_i != 8'h00 && csr_mstatus_i[3] && !ex_busy_i) begin
        cause = 32'h8000_0000;
        for (int i = 7; i >= 0; i--) if (int_flag_i[i]) cause = 32'h8000_0000 + i;
        push_entry(jump_flag_i ? jump_addr_i : inst_addr_i, cause);
`endif
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
      end
    end
    e = exp_q.pop_front();
    if (rst_i) exp_q.delete();
  endtask

  // Inputs are already set just after a falling edge; check mid-low-phase.
  task automatic tick();
    out_t e;
    model_cycle(e);
    #2;
    got = mk(hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
    chk("cycle", 128'(got), 128'(e));
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    inst_i      = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET :
                  (r < 6) ? NOP : $urandom;
    inst_addr_i = {$urandom_range(0, 32'h3fff_ffff), 2'b00} & 32'hffff_fffc;
    jump_flag_i = ($urandom_range(0, 3) == 0);
    jump_addr_i = $urandom & 32'hffff_fffc;
    int_flag_i  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
    ex_busy_i   = ($urandom_range(0, 3) == 0);
    if (exp_q.size() == 0) begin
      csr_mstatus_i = $urandom;
      csr_mtvec_i   = $urandom;
      csr_mepc_i    = $urandom;
    end
  endtask

  task automatic quiet();
    inst_i = NOP; jump_flag_i = 1'b0; int_flag_i = 8'h00; ex_busy_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; quiet();
    inst_addr_i = 32'h0; jump_addr_i = 32'h0;
    csr_mtvec_i = 32'h0; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h0;
    @(negedge clk); @(negedge clk);
    tick();
    chk("reset_outputs", 128'(got), 128'h0);
    rst_i = 1'b0;
    tick();

    // ecall at 0x100, mtvec 0x800, mstatus 0x8
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h800; csr_mstatus_i = 32'h8;
    tick(); chk("ecall_hold_T", 128'(got.hold), 128'h1);
    quiet();
    tick(); chk("ecall_mepc", 128'({got.we, got.waddr, got.wdata}), 128'({1'b1, 12'h341, 32'h100}));
    tick(); chk("ecall_mcause", 128'({got.we, got.waddr, got.wdata}), 128'({1'b1, 12'h342, 32'd11}));
    tick(); chk("ecall_mstatus", 128'({got.we, got.waddr, got.wdata}), 128'({1'b1, 12'h300, 32'h80}));
    tick(); chk("ecall_redirect", 128'({got.hold, got.asrt, got.addr, got.we}), 128'({1'b1, 1'b1, 32'h800, 1'b0}));
    tick(); chk("ecall_done", 128'({got.hold, got.asrt}), 128'h0);

    // mret with mepc 0x104, mstatus 0x80
    inst_i = MRET; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80;
    tick(); chk("mret_hold_T", 128'(got.hold), 128'h1);
    quiet();
    tick(); chk("mret_mstatus", 128'({got.we, got.waddr, got.wdata}), 128'({1'b1, 12'h300, 32'h88}));
    tick(); chk("mret_redirect", 128'({got.hold, got.asrt, got.addr}), 128'({1'b1, 1'b1, 32'h104}));
    tick(); chk("mret_done", 128'({got.hold, got.asrt}), 128'h0);

    // ecall on a flushed path
    inst_i = ECALL; jump_flag_i = 1'b1; jump_addr_i = 32'h300; csr_mstatus_i = 32'h0;
    tick(); chk("flushed_ecall_hold", 128'(got.hold), 128'h0);
    quiet();
    tick(); chk("flushed_ecall_we", 128'({got.hold, got.we}), 128'h0);

`ifdef TRAP_CTRL_ASYNC_IRQ_EN
    // interrupt line 2 while a jump to 0x200 is taken
    csr_mstatus_i = 32'h8; int_flag_i = 8'b0000_0100; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    tick(); chk("irq_hold_T", 128'(got.hold), 128'h1);
    quiet();
    tick(); chk("irq_mepc", 128'({got.waddr, got.wdata}), 128'({12'h341, 32'h200}));
    tick(); chk("irq_mcause", 128'({got.waddr, got.wdata}), 128'({12'h342, 32'h8000_0002}));
    tick(); tick(); tick();
`endif

    // interrupt deferred by ex_busy for 3 cycles
    csr_mstatus_i = 32'h8; int_flag_i = 8'h10; ex_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("busy_defers_irq", 128'(got.hold), 128'h0);
    end
    ex_busy_i = 1'b0;
    tick();
`ifdef TRAP_CTRL_ASYNC_IRQ_EN
    chk("irq_after_busy", 128'(got.hold), 128'h1);
`endif
    quiet();
    for (int i = 0; i < 5; i++) tick();

    // reset in the middle of an ecall sequence
    inst_i = ECALL; inst_addr_i = 32'h400; csr_mstatus_i = 32'h8;
    tick(); quiet();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick(); chk("abort_outputs_zero", 128'(got), 128'h0);
    tick(); chk("abort_no_redirect", 128'({got.asrt, got.hold}), 128'h0);

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
